// File: rtl/uart_pkg.sv
// Shared types and constants for the multi-requester UART transmit scheduler.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitAck,
    StWaitDone
  } tx_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of valid at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               any_valid,
  output logic [ID_W-1:0]    pick
);

  logic [ID_W-1:0] cand;

  always_comb begin
    any_valid = 1'b0;
    pick      = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!any_valid && valid[cand]) begin
        any_valid = 1'b1;
        pick      = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-granular round-robin scheduler feeding one UART transmitter.
// Optional owner-stall timeout is enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                           serial_clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_start,
  input  logic                           tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           grant_active
`ifdef UART_TX_SCHED_TIMEOUT_EN
  ,
  output logic                           timeout_flag
`endif
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_sched: parameter out of range");
  end

  tx_state_e              state_q;
  logic [ID_W-1:0]        rr_ptr_q;
  logic [ID_W-1:0]        next_ptr;
  logic [ID_W-1:0]        pick;
  logic                   pick_any;
  logic                   last_q;
  logic                   sel_valid;
  logic                   sel_last;
  logic [UART_BYTE_W-1:0] sel_data;
  logic                   accept;
  logic                   timeout_hit;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr_pick (
    .valid    (req_valid),
    .ptr      (rr_ptr_q),
    .any_valid(pick_any),
    .pick     (pick)
  );

  // Owner's lane, selected by the registered grant.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*UART_BYTE_W +: UART_BYTE_W];
      end
    end
  end

  assign accept   = (state_q == StSend) && sel_valid && !tx_busy;
  assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        req_ready[i] = accept;
      end
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] stall_cnt_q;

  assign timeout_hit = (state_q == StSend) && !sel_valid &&
                       (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge serial_clk) begin
    if (!reset_n) begin
      stall_cnt_q  <= '0;
      timeout_flag <= 1'b0;
    end else begin
      timeout_flag <= timeout_hit;
      if (accept || timeout_hit || state_q == StIdle) begin
        stall_cnt_q <= '0;
      end else if (state_q == StSend && !sel_valid) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge serial_clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      last_q       <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_any) begin
            grant_id     <= pick;
            grant_active <= 1'b1;
            state_q      <= StSend;
          end
        end
        StSend: begin
          if (accept) begin
            tx_data  <= sel_data;
            tx_start <= 1'b1;
            last_q   <= sel_last;
            state_q  <= StWaitAck;
          end else if (timeout_hit) begin
            rr_ptr_q     <= next_ptr;
            grant_active <= 1'b0;
            state_q      <= StIdle;
          end
        end
        StWaitAck: begin
          if (tx_busy) begin
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          // Packet end releases the transmitter; a new request is seen from IDLE next cycle.
          if (!tx_busy) begin
            if (last_q) begin
              rr_ptr_q     <= next_ptr;
              grant_active <= 1'b0;
              state_q      <= StIdle;
            end else begin
              state_q <= StSend;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a simple busy-counter transmitter model.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic [1:0] req_valid, req_last, req_ready;
  logic [15:0] req_data;
  logic [7:0] tx_data;
  logic       tx_start, tx_busy, grant_active;
  logic       grant_id;
`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic       timeout_flag;
`endif

  int         asserts = 0;
  int         fails = 0;
  int         busy_len = 20;
  int         bcnt = 0;
  int         dbl = 0;
  int         flag_cnt = 0;
  logic       start_prev = 1'b0;
  logic [7:0] log_d[$];
  logic       log_g[$];

  assign req_valid = {v1, v0};
  assign req_last  = {l1, l0};
  assign req_data  = {d1, d0};
  assign tx_busy   = (bcnt != 0);

  always #5 clk = ~clk;

  uart_tx_sched #(
    .NUM_REQ       (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .serial_clk  (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .grant_active(grant_active)
`ifdef UART_TX_SCHED_TIMEOUT_EN
    ,
    .timeout_flag(timeout_flag)
`endif
  );

  // Transmitter model and start-strobe logger.
  always @(posedge clk) begin
    if (!reset_n) bcnt <= 0;
    else if (tx_start) bcnt <= busy_len;
    else if (bcnt != 0) bcnt <= bcnt - 1;
    if (tx_start) begin
      log_d.push_back(tx_data);
      log_g.push_back(grant_id);
    end
    if (tx_start && start_prev) dbl <= dbl + 1;
    start_prev <= tx_start;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    if (timeout_flag) flag_cnt <= flag_cnt + 1;
`endif
  end

  task automatic drive(input int r, input logic v, input logic [7:0] d, input logic l);
    if (r == 0) begin v0 = v; d0 = d; l0 = l; end
    else begin v1 = v; d1 = d; l1 = l; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic send_pkt(input int r, input int n, input logic [23:0] bytes,
                          input logic end_last);
    int  cyc;
    logic acc;
    for (int b = 0; b < n; b++) begin
      drive(r, 1'b1, bytes[8*b +: 8], (b == n - 1) && end_last);
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 400) begin
        @(negedge clk);
        acc = req_ready[r];
        @(posedge clk);
        #1 cyc++;
      end
      asserts++;
      if (!acc) begin
        fails++;
        $display("FAIL accept_r%0d_b%0d: not accepted after %0d cycles, required <400", r, b, cyc);
      end
    end
    drive(r, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!tx_busy && n < 100) begin @(posedge clk); #1 n++; end
    while (tx_busy && n < 200) begin @(posedge clk); #1 n++; end
    asserts++;
    if (tx_busy || n >= 100 && n < 101) begin
      fails++;
      $display("FAIL wait_done: busy=%0b after %0d cycles, required busy pulse then 0", tx_busy, n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 1'b1, 8'h5A, 1'b1);
    drive(1, 1'b1, 8'hA5, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    asserts += 5;
    if (grant_active !== 1'b0) begin fails++; $display("FAIL rst_gact: got %b, expected 0", grant_active); end
    if (tx_start !== 1'b0) begin fails++; $display("FAIL rst_start: got %b, expected 0", tx_start); end
    if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_data: got %h, expected 00", tx_data); end
    if (req_ready !== 2'b00) begin fails++; $display("FAIL rst_ready: got %b, expected 00", req_ready); end
    if (grant_id !== 1'b0) begin fails++; $display("FAIL rst_gid: got %b, expected 0", grant_id); end
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int base, dbase, n;
    logic [7:0] exp_d[3];
    exp_d = '{8'h4E, 8'h69, 8'h4F};
    do_reset();
    busy_len = 20;
    base = log_d.size();
    dbase = dbl;
    send_pkt(0, 3, {8'h4F, 8'h69, 8'h4E}, 1'b1);
    n = 0;
    while (!tx_busy && n < 50) begin @(posedge clk); #1 n++; end
    while (tx_busy && n < 100) begin @(posedge clk); #1 n++; end
    asserts += 3;
    if (grant_active !== 1'b1) begin fails++; $display("FAIL single_gact_hold: got %b, expected 1", grant_active); end
    @(posedge clk);
    #1;
    if (grant_active !== 1'b0) begin fails++; $display("FAIL single_gact_drop: got %b, expected 0", grant_active); end
    if (dut.rr_ptr_q !== 1'b1) begin fails++; $display("FAIL single_rr_ptr: got %b, expected 1", dut.rr_ptr_q); end
    asserts += 2;
    if (log_d.size() - base !== 3) begin fails++; $display("FAIL single_count: got %0d, expected 3", log_d.size() - base); end
    if (dbl !== dbase) begin fails++; $display("FAIL single_strobe_len: got %0d long strobes, expected 0", dbl - dbase); end
    for (int i = 0; i < 3; i++) begin
      asserts++;
      if (log_d[base+i] !== exp_d[i]) begin
        fails++;
        $display("FAIL single_byte%0d: got %h, expected %h", i, log_d[base+i], exp_d[i]);
      end
    end
  endtask

  task automatic test_contention();
    int base;
    logic [7:0] exp_d[3];
    logic       exp_g[3];
    exp_d = '{8'hAA, 8'hBB, 8'hCC};
    exp_g = '{1'b0, 1'b0, 1'b1};
    do_reset();
    base = log_d.size();
    fork
      send_pkt(0, 2, {8'h00, 8'hBB, 8'hAA}, 1'b1);
      send_pkt(1, 1, {16'h0000, 8'hCC}, 1'b1);
    join
    wait_done();
    for (int i = 0; i < 3; i++) begin
      asserts += 2;
      if (log_d[base+i] !== exp_d[i]) begin fails++; $display("FAIL contend_byte%0d: got %h, expected %h", i, log_d[base+i], exp_d[i]); end
      if (log_g[base+i] !== exp_g[i]) begin fails++; $display("FAIL contend_gid%0d: got %b, expected %b", i, log_g[base+i], exp_g[i]); end
    end
  endtask

  task automatic test_fairness();
    int base;
    logic [7:0] exp_d[4];
    logic       exp_g[4];
    exp_d = '{8'h10, 8'h20, 8'h11, 8'h21};
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    base = log_d.size();
    fork
      begin
        send_pkt(0, 1, {16'h0000, 8'h10}, 1'b1);
        send_pkt(0, 1, {16'h0000, 8'h11}, 1'b1);
      end
      begin
        send_pkt(1, 1, {16'h0000, 8'h20}, 1'b1);
        send_pkt(1, 1, {16'h0000, 8'h21}, 1'b1);
      end
    join
    wait_done();
    for (int i = 0; i < 4; i++) begin
      asserts += 2;
      if (log_g[base+i] !== exp_g[i]) begin fails++; $display("FAIL fair_gid%0d: got %b, expected %b", i, log_g[base+i], exp_g[i]); end
      if (log_d[base+i] !== exp_d[i]) begin fails++; $display("FAIL fair_byte%0d: got %h, expected %h", i, log_d[base+i], exp_d[i]); end
    end
  endtask

`ifndef UART_TX_SCHED_TIMEOUT_EN
  task automatic test_owner_stall();
    int base;
    logic [7:0] exp_d[3];
    logic       exp_g[3];
    exp_d = '{8'h31, 8'h32, 8'h40};
    exp_g = '{1'b1, 1'b1, 1'b0};
    do_reset();
    busy_len = 20;
    base = log_d.size();
    fork
      begin
        send_pkt(1, 1, {16'h0000, 8'h31}, 1'b0);
        repeat (25) @(posedge clk);
        #1;
        asserts += 3;
        if (grant_id !== 1'b1) begin fails++; $display("FAIL stall_gid: got %b, expected 1", grant_id); end
        if (grant_active !== 1'b1) begin fails++; $display("FAIL stall_gact: got %b, expected 1", grant_active); end
        if (req_ready !== 2'b00) begin fails++; $display("FAIL stall_ready: got %b, expected 00", req_ready); end
        repeat (25) @(posedge clk);
        #1;
        send_pkt(1, 1, {16'h0000, 8'h32}, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        send_pkt(0, 1, {16'h0000, 8'h40}, 1'b1);
      end
    join
    wait_done();
    for (int i = 0; i < 3; i++) begin
      asserts += 2;
      if (log_d[base+i] !== exp_d[i]) begin fails++; $display("FAIL stall_byte%0d: got %h, expected %h", i, log_d[base+i], exp_d[i]); end
      if (log_g[base+i] !== exp_g[i]) begin fails++; $display("FAIL stall_gid%0d: got %b, expected %b", i, log_g[base+i], exp_g[i]); end
    end
  endtask
`else
  task automatic test_timeout();
    int base, fbase, n;
    do_reset();
    busy_len = 2;
    base = log_d.size();
    fbase = flag_cnt;
    fork
      begin
        send_pkt(1, 1, {16'h0000, 8'h51}, 1'b0);
        n = 0;
        while (timeout_flag !== 1'b1 && n < 100) begin @(posedge clk); #1 n++; end
        asserts += 2;
        if (n !== 20) begin fails++; $display("FAIL timeout_cycle: got %0d, expected 20", n); end
        @(posedge clk);
        #1;
        if (timeout_flag !== 1'b0) begin fails++; $display("FAIL timeout_pulse: got %b, expected 0", timeout_flag); end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        send_pkt(0, 1, {16'h0000, 8'h60}, 1'b1);
      end
    join
    wait_done();
    asserts += 5;
    if (flag_cnt - fbase !== 1) begin fails++; $display("FAIL timeout_count: got %0d, expected 1", flag_cnt - fbase); end
    if (log_d[base] !== 8'h51) begin fails++; $display("FAIL timeout_byte0: got %h, expected 51", log_d[base]); end
    if (log_g[base] !== 1'b1) begin fails++; $display("FAIL timeout_gid0: got %b, expected 1", log_g[base]); end
    if (log_d[base+1] !== 8'h60) begin fails++; $display("FAIL timeout_byte1: got %h, expected 60", log_d[base+1]); end
    if (log_g[base+1] !== 1'b0) begin fails++; $display("FAIL timeout_gid1: got %b, expected 0", log_g[base+1]); end
  endtask
`endif

  task automatic test_reset_mid_packet();
    int n, sbase;
    do_reset();
    busy_len = 20;
    send_pkt(1, 1, {16'h0000, 8'h71}, 1'b0);
    drive(1, 1'b1, 8'h72, 1'b1);
    n = 0;
    while (!tx_busy && n < 50) begin @(posedge clk); #1 n++; end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1;
    asserts += 5;
    if (grant_active !== 1'b0) begin fails++; $display("FAIL mid_gact: got %b, expected 0", grant_active); end
    if (tx_start !== 1'b0) begin fails++; $display("FAIL mid_start: got %b, expected 0", tx_start); end
    if (tx_data !== 8'h00) begin fails++; $display("FAIL mid_data: got %h, expected 00", tx_data); end
    if (req_ready !== 2'b00) begin fails++; $display("FAIL mid_ready: got %b, expected 00", req_ready); end
    if (grant_id !== 1'b0) begin fails++; $display("FAIL mid_gid: got %b, expected 0", grant_id); end
    drive(1, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b1;
    sbase = log_d.size();
    repeat (40) @(posedge clk);
    #1;
    asserts++;
    if (log_d.size() !== sbase) begin fails++; $display("FAIL mid_quiet: got %0d starts, expected 0", log_d.size() - sbase); end
    send_pkt(1, 1, {16'h0000, 8'h73}, 1'b1);
    wait_done();
    asserts += 2;
    if (log_d[sbase] !== 8'h73) begin fails++; $display("FAIL mid_restart_byte: got %h, expected 73", log_d[sbase]); end
    if (log_g[sbase] !== 1'b1) begin fails++; $display("FAIL mid_restart_gid: got %b, expected 1", log_g[sbase]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
`ifndef UART_TX_SCHED_TIMEOUT_EN
    test_owner_stall();
`else
    test_timeout();
`endif
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
